alu_lockstep_seq: RTL and testbench

- Self-test sequencer for the dual-lane 4-bit lockstep ALU (alu_xor_4).
- On start, drives an index-derived operand/select vector into both lanes and waits out the ALU's registered latency.
- Samples the lane-compare outputs (x, y), counts mismatches and records the first failing vector index.
- Sits between management control (LA/Wishbone-driven start/abort) and the ALU operand inputs.

---
 rtl/alu_lockstep_seq.sv | 177 +++++++++++++++++
 tb/tb_alu_lockstep_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_lockstep_seq.sv
// ============================================================================
// alu_lockstep_seq : self-test sequencer for the dual-lane lockstep ALU.
// Optional fault injection on lane 1 operand B: ALU_SEQ_FAULT_INJ_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_lockstep_seq #(
   parameter int ALU_LAT = 1,
   parameter int IDX_W   = 10,
   parameter int ERR_W   = 8
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_ni,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [IDX_W-1:0] vec_last_i,
`ifdef ALU_SEQ_FAULT_INJ_EN
   input  logic             fault_en_i,
   input  logic [IDX_W-1:0] fault_idx_i,
`endif
   output logic [3:0]       a0_o,
   output logic [3:0]       b0_o,
   output logic [3:0]       a1_o,
   output logic [3:0]       b1_o,
   output logic [1:0]       sel1_o,
   output logic [1:0]       sel2_o,
   input  logic [3:0]       x_i,
   input  logic             y_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
   output logic [ERR_W-1:0] err_cnt_o,
   output logic [IDX_W-1:0] first_fail_o,
   output logic             first_fail_vld_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DRIVE = 3'd1,
      S_WAIT  = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [ERR_W-1:0] c_ERR_MAX  = '1;
   localparam logic [2:0]       c_WAIT_INI = 3'(ALU_LAT - 1);

   state_t           r_state;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] r_last;
   logic [2:0]       r_wcnt;
   logic [3:0]       r_a0, r_b0, r_a1, r_b1;
   logic [1:0]       r_sel1, r_sel2;
   logic             r_busy, r_done, r_pass, r_ffv;
   logic [ERR_W-1:0] r_err;
   logic [IDX_W-1:0] r_ff;
   logic             w_mismatch, w_err_inc, w_flip;
   logic [ERR_W-1:0] w_err_next;

`ifdef ALU_SEQ_FAULT_INJ_EN
   logic             r_fen;
   logic [IDX_W-1:0] r_fidx;
   assign w_flip = r_fen && (r_idx == r_fidx);
`else
   assign w_flip = 1'b0;
`endif

   assign w_mismatch = (|x_i) | y_i;
   assign w_err_inc  = (r_state == S_CHECK) && w_mismatch && (r_err != c_ERR_MAX);
   assign w_err_next = r_err + ERR_W'(w_err_inc);

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_last  <= '0;
         r_wcnt  <= '0;
         r_a0    <= '0;
         r_b0    <= '0;
         r_a1    <= '0;
         r_b1    <= '0;
         r_sel1  <= '0;
         r_sel2  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
         r_ffv   <= 1'b0;
         r_err   <= '0;
         r_ff    <= '0;
`ifdef ALU_SEQ_FAULT_INJ_EN
         r_fen   <= 1'b0;
         r_fidx  <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start_i && !abort_i) begin
                  r_state <= S_DRIVE;
                  r_busy  <= 1'b1;
                  r_last  <= vec_last_i;
                  r_idx   <= '0;
                  r_err   <= '0;
                  r_ffv   <= 1'b0;
                  r_pass  <= 1'b0;
`ifdef ALU_SEQ_FAULT_INJ_EN
                  r_fen   <= fault_en_i;
                  r_fidx  <= fault_idx_i;
`endif
               end
            end
            S_DRIVE: begin
               r_a0    <= r_idx[3:0];
               r_a1    <= r_idx[3:0];
               r_b0    <= r_idx[7:4];
               r_b1    <= r_idx[7:4] ^ {3'b000, w_flip};
               r_sel1  <= r_idx[9:8];
               r_sel2  <= r_idx[9:8];
               r_wcnt  <= c_WAIT_INI;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (r_wcnt == 3'd0) r_state <= S_CHECK;
               else                r_wcnt  <= r_wcnt - 3'd1;
            end
            S_CHECK: begin
               r_err <= w_err_next;
               if (w_mismatch && !r_ffv) begin
                  r_ff  <= r_idx;
                  r_ffv <= 1'b1;
               end
               if (r_idx == r_last) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_pass  <= (w_err_next == '0);
               end else begin
                  r_idx   <= r_idx + 1'b1;
                  r_state <= S_DRIVE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
         // Abort overrides the state move but keeps any error bookkeeping done above.
         if (abort_i && (r_state != S_IDLE)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
         end
      end
   end

   assign a0_o             = r_a0;
   assign b0_o             = r_b0;
   assign a1_o             = r_a1;
   assign b1_o             = r_b1;
   assign sel1_o           = r_sel1;
   assign sel2_o           = r_sel2;
   assign busy_o           = r_busy;
   // An abort arriving during DONE suppresses the completion pulse.
   assign done_o           = r_done & ~abort_i;
   assign pass_o           = r_pass;
   assign err_cnt_o        = r_err;
   assign first_fail_o     = r_ff;
   assign first_fail_vld_o = r_ffv;

endmodule

`default_nettype wire

// File: tb/tb_alu_lockstep_seq.sv
// ============================================================================
// tb_alu_lockstep_seq : self-checking bench with a lockstep ALU model.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alu_lockstep_seq;
   localparam int ALU_LAT = 1;
   localparam int IDX_W   = 10;
   localparam int ERR_W   = 8;
   localparam int LC      = ALU_LAT + 2;
   localparam int ERR_MAX = (1 << ERR_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start_i = 1'b0, abort_i = 1'b0;
   logic [IDX_W-1:0] vec_last_i = '0;
   logic             fault_en_i = 1'b0;
   logic [IDX_W-1:0] fault_idx_i = '0;
   logic [3:0]       a0, b0, a1, b1, x_i;
   logic [1:0]       sel1, sel2;
   logic             y_i, busy, done, pass, ffv;
   logic [ERR_W-1:0] err;
   logic [IDX_W-1:0] ff;

   int n_chk = 0, n_pass = 0;
   bit fmask [1024];
   bit xstuck = 1'b0;
   bit [4:0] pipe [ALU_LAT];

   always #5 clk = ~clk;

   alu_lockstep_seq #(.ALU_LAT(ALU_LAT), .IDX_W(IDX_W), .ERR_W(ERR_W)) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start_i), .abort_i(abort_i),
      .vec_last_i(vec_last_i),
`ifdef ALU_SEQ_FAULT_INJ_EN
      .fault_en_i(fault_en_i), .fault_idx_i(fault_idx_i),
`endif
      .a0_o(a0), .b0_o(b0), .a1_o(a1), .b1_o(b1), .sel1_o(sel1), .sel2_o(sel2),
      .x_i(x_i), .y_i(y_i), .busy_o(busy), .done_o(done), .pass_o(pass),
      .err_cnt_o(err), .first_fail_o(ff), .first_fail_vld_o(ffv)
   );

   function automatic logic [4:0] alu(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
      case (s)
         2'd0:    alu = {1'b0, a} + {1'b0, b};
         2'd1:    alu = {1'b0, a} - {1'b0, b};
         2'd2:    alu = {1'b0, a & b};
         default: alu = {1'b0, a | b};
      endcase
   endfunction

   // Two-lane ALU with registered latency; fmask forces a carry-compare hit per index.
   always @(posedge clk) begin
      pipe[0] <= (alu(a0, b0, sel1) ^ alu(a1, b1, sel2)) | {fmask[{sel1, b0, a0}], 4'b0000};
      for (int i = 1; i < ALU_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign x_i = xstuck ? 4'h1 : pipe[ALU_LAT-1][3:0];
   assign y_i = pipe[ALU_LAT-1][4];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic clear_faults();
      for (int i = 0; i < 1024; i++) fmask[i] = 1'b0;
      xstuck = 1'b0;
   endtask

   // Reference: which vectors of a run mismatch, from the ALU rules and fault setup.
   task automatic model(input int last, input bit fen, input int fidx,
                        output int n_err, output int first);
      int cnt;
      logic [9:0] k;
      logic [3:0] bb;
      cnt = 0; first = -1;
      for (int i = 0; i <= last; i++) begin
         bit mis;
         k = 10'(i);
         bb = k[7:4] ^ {3'b000, (fen && i == fidx)};
         mis = xstuck || fmask[i] || (alu(k[3:0], k[7:4], k[9:8]) != alu(k[3:0], bb, k[9:8]));
         if (mis) begin
            cnt++;
            if (first < 0) first = i;
         end
      end
      n_err = (cnt > ERR_MAX) ? ERR_MAX : cnt;
   endtask

   task automatic run(input int last, input bit fen, input int fidx, input bit poke_start);
      int total, e_err, e_first;
      bit early;
      logic [9:0] k;
      model(last, fen, fidx, e_err, e_first);
      total = (last + 1) * LC;
      early = 1'b0;
      @(negedge clk);
      vec_last_i  = IDX_W'(last);
      fault_en_i  = fen;
      fault_idx_i = IDX_W'(fidx);
      start_i     = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      chk("busy_after_start", 64'(busy), 64'd1);
      for (int c = 1; c <= total; c++) begin
         @(posedge clk); #1;
         start_i = 1'b0;
         if (poke_start && c == 1) begin
            start_i    = 1'b1;
            vec_last_i = '0;
         end
         if (done && c < total) early = 1'b1;
         if (last < 64 && ((c - 1) % LC) == 0) begin
            k = 10'((c - 1) / LC);
            chk("operands", {48'd0, a0, b0, a1, b1, sel1, sel2},
                {48'd0, k[3:0], k[7:4], k[3:0], k[7:4] ^ {3'b000, (fen && int'(k) == fidx)}, k[9:8], k[9:8]});
         end
      end
      chk("no_early_done", 64'(early), 64'd0);
      chk("done_pulse", 64'(done), 64'd1);
      chk("pass", 64'(pass), 64'(e_err == 0));
      chk("err_cnt", 64'(err), 64'(e_err));
      chk("first_fail_vld", 64'(ffv), 64'(e_first >= 0));
      if (e_first >= 0) chk("first_fail", 64'(ff), 64'(e_first));
      @(posedge clk); #1;
      chk("done_one_cycle", 64'(done), 64'd0);
      chk("idle_after_done", 64'(busy), 64'd0);
   endtask

   initial begin
      int e_err, e_first;
      bit seen;
      clear_faults();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {a0, b0, a1, b1, sel1, sel2, busy, done, pass, err, ff, ffv}, '0);
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(posedge clk);

      run(3, 1'b0, 0, 1'b1);

      fmask[5] = 1'b1; fmask[700] = 1'b1;
      run(1023, 1'b0, 0, 1'b0);
      chk("full_run_ff5", 64'(ff), 64'd5);

      clear_faults(); xstuck = 1'b1;
      run(9, 1'b0, 0, 1'b0);
      run(299, 1'b0, 0, 1'b0);
      chk("err_saturated", 64'(err), 64'(ERR_MAX));

      // Abort during CHECK of vector 2 which mismatches.
      clear_faults(); fmask[2] = 1'b1;
      @(negedge clk); vec_last_i = 10'd9; start_i = 1'b1;
      @(posedge clk); #1; start_i = 1'b0;
      repeat (2 * LC + ALU_LAT + 1) @(posedge clk);
      #1; abort_i = 1'b1;
      @(posedge clk); #1; abort_i = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_err", 64'(err), 64'd1);
      chk("abort_ff", {ffv, ff}, {1'b1, 10'd2});
      chk("abort_pass", 64'(pass), 64'd0);
      seen = 1'b0;
      for (int c = 0; c < 4 * LC; c++) begin
         @(posedge clk); #1;
         if (done || busy) seen = 1'b1;
      end
      chk("abort_no_done", 64'(seen), 64'd0);

      // Abort together with start in IDLE must not start a run.
      @(negedge clk); start_i = 1'b1; abort_i = 1'b1;
      @(posedge clk); #1; start_i = 1'b0; abort_i = 1'b0;
      chk("abort_beats_start", 64'(busy), 64'd0);

      for (int r = 0; r < 4; r++) begin
         int last;
         clear_faults();
         last = int'($urandom_range(0, 40));
         for (int i = 0; i <= last; i++) fmask[i] = ($urandom_range(0, 7) == 0);
         model(last, 1'b0, 0, e_err, e_first);
         run(last, 1'b0, 0, 1'b0);
      end

      // Reset mid-WAIT of vector 5.
      clear_faults();
      @(negedge clk); vec_last_i = 10'd20; start_i = 1'b1;
      @(posedge clk); #1; start_i = 1'b0;
      repeat (5 * LC + 1) @(posedge clk);
      #2; rst_n = 1'b0;
      #1;
      chk("reset_midrun", {a0, b0, a1, b1, sel1, sel2, busy, done, pass, err, ff, ffv}, '0);
      seen = 1'b0;
      repeat (3) begin @(posedge clk); #1; if (done || busy) seen = 1'b1; end
      chk("reset_no_done", 64'(seen), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk);

`ifdef ALU_SEQ_FAULT_INJ_EN
      clear_faults();
      run(8'h3F, 1'b1, 8'h2A, 1'b0);
      chk("finj_err", 64'(err), 64'd1);
      chk("finj_ff", 64'(ff), 64'h2A);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

`default_nettype wire
